calc_entry: RTL and testbench

- Operand-entry controller directly upstream of the calculator ALU.
- Consumes single-cycle key events (digits, +, -, =, clear) and builds BCD operands digit by digit.
- Drives left/right operands and the operation to the combinational ALU, then captures the ALU result back as the new left operand so operations can be chained.
- Provides the number currently to be displayed.

---
 rtl/calc_pkg.sv | 53 +++++
 rtl/calc_operand_reg.sv | 52 +++++
 rtl/calc_entry.sv | 162 ++++++++++++++++
 tb/tb_calc_entry.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator types: BCD operand, ALU op, key codes and entry FSM states.
package calc_pkg;

    localparam int unsigned NumDigits = 4;
    localparam int unsigned DigitW    = 4;
    localparam int unsigned CntW      = $clog2(NumDigits + 1);

    typedef logic [DigitW-1:0] digit_t;

    typedef struct packed {
        digit_t [NumDigits-1:0] significand;
    } num_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } op_t;

    typedef enum logic [3:0] {
        KEY_0   = 4'd0,
        KEY_1   = 4'd1,
        KEY_2   = 4'd2,
        KEY_3   = 4'd3,
        KEY_4   = 4'd4,
        KEY_5   = 4'd5,
        KEY_6   = 4'd6,
        KEY_7   = 4'd7,
        KEY_8   = 4'd8,
        KEY_9   = 4'd9,
        KEY_ADD = 4'd10,
        KEY_SUB = 4'd11,
        KEY_EQ  = 4'd12,
        KEY_CLR = 4'd13
    } key_t;

    typedef enum logic [2:0] {
        S_LEFT   = 3'd0,
        S_OP     = 3'd1,
        S_RIGHT  = 3'd2,
        S_EXEC   = 3'd3,
        S_RESULT = 3'd4
    } entry_state_t;

    function automatic logic is_digit(input key_t k);
        return (k <= KEY_9);
    endfunction

    function automatic digit_t key_to_digit(input key_t k);
        return digit_t'(k);
    endfunction

endpackage

// File: rtl/calc_operand_reg.sv
// One BCD operand with its entered-digit count: clear, shift-in digit, or parallel load.
module calc_operand_reg
    import calc_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   clear_i,
    input  logic   shift_i,
    input  digit_t digit_i,
    input  logic   load_i,
    input  num_t   load_val_i,
    output num_t   val_o,
    output num_t   val_nxt_c_o
);

    num_t            val_q, val_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Clear applies first so "clear then shift" happens in a single edge.
    always_comb begin
        val_d = val_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            val_d = '0;
            cnt_d = '0;
        end
        if (load_i) begin
            val_d = load_val_i;
            cnt_d = CntW'(NumDigits);
        end else if (shift_i) begin
            // Full operands and leading zeros leave the operand untouched.
            if ((cnt_d != CntW'(NumDigits)) && !((cnt_d == '0) && (digit_i == '0))) begin
                val_d.significand = {val_d.significand[NumDigits-2:0], digit_i};
                cnt_d             = cnt_d + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            val_q <= '0;
            cnt_q <= '0;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
        end
    end

    assign val_o       = val_q;
    assign val_nxt_c_o = val_d;

endmodule

// File: rtl/calc_entry.sv
// Operand-entry controller: turns key events into ALU operands/op and chains ALU results.
module calc_entry
    import calc_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_valid_i,
    input  key_t key_i,
    output logic key_ready_o,
    output num_t left_o,
    output num_t right_o,
    output op_t  op_o,
    input  num_t result_i,
    output num_t display_o
);

    entry_state_t state_q, state_d;
    op_t          op_q, op_d;
    op_t          pend_q, pend_d;
    logic         chain_q, chain_d;
    logic         ready_q, ready_d;
    num_t         disp_q, disp_d;

    logic   l_clr, l_shift, l_load;
    logic   r_clr, r_shift;
    logic   acc, dig, is_op;
    digit_t digit;
    op_t    key_op;
    num_t   l_nxt, r_nxt;

    assign acc    = key_valid_i && ready_q;
    assign dig    = is_digit(key_i);
    assign digit  = key_to_digit(key_i);
    assign is_op  = (key_i == KEY_ADD) || (key_i == KEY_SUB);
    assign key_op = (key_i == KEY_SUB) ? OP_SUB : OP_ADD;

    // Next-state, operand control and registered-output next values.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        pend_d  = pend_q;
        chain_d = chain_q;
        l_clr   = 1'b0;
        l_shift = 1'b0;
        l_load  = 1'b0;
        r_clr   = 1'b0;
        r_shift = 1'b0;

        if (state_q == S_EXEC) begin
            l_load = 1'b1;
            if (chain_q) begin
                op_d    = pend_q;
                state_d = S_OP;
            end else begin
                state_d = S_RESULT;
            end
        end else if (acc) begin
            if (key_i == KEY_CLR) begin
                l_clr   = 1'b1;
                r_clr   = 1'b1;
                op_d    = OP_NONE;
                pend_d  = OP_NONE;
                chain_d = 1'b0;
                state_d = S_LEFT;
            end else begin
                case (state_q)
                    S_LEFT: begin
                        if (dig) begin
                            l_shift = 1'b1;
                        end else if (is_op) begin
                            op_d    = key_op;
                            state_d = S_OP;
                        end
                    end
                    S_OP: begin
                        if (dig) begin
                            r_clr   = 1'b1;
                            r_shift = 1'b1;
                            state_d = S_RIGHT;
                        end else if (is_op) begin
                            op_d = key_op;
                        end
                    end
                    S_RIGHT: begin
                        if (dig) begin
                            r_shift = 1'b1;
                        end else if (key_i == KEY_EQ) begin
                            chain_d = 1'b0;
                            state_d = S_EXEC;
                        end else if (is_op) begin
                            chain_d = 1'b1;
                            pend_d  = key_op;
                            state_d = S_EXEC;
                        end
                    end
                    S_RESULT: begin
                        if (dig) begin
                            l_clr   = 1'b1;
                            l_shift = 1'b1;
                            op_d    = OP_NONE;
                            state_d = S_LEFT;
                        end else if (is_op) begin
                            op_d    = key_op;
                            state_d = S_OP;
                        end
                    end
                    default: state_d = S_LEFT;
                endcase
            end
        end

        ready_d = (state_d != S_EXEC);
        disp_d  = ((state_d == S_RIGHT) || (state_d == S_EXEC)) ? r_nxt : l_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_LEFT;
            op_q    <= OP_NONE;
            pend_q  <= OP_NONE;
            chain_q <= 1'b0;
            ready_q <= 1'b1;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pend_q  <= pend_d;
            chain_q <= chain_d;
            ready_q <= ready_d;
            disp_q  <= disp_d;
        end
    end

    calc_operand_reg u_left (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (l_clr),
        .shift_i    (l_shift),
        .digit_i    (digit),
        .load_i     (l_load),
        .load_val_i (result_i),
        .val_o      (left_o),
        .val_nxt_c_o(l_nxt)
    );

    calc_operand_reg u_right (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (r_clr),
        .shift_i    (r_shift),
        .digit_i    (digit),
        .load_i     (1'b0),
        .load_val_i ('0),
        .val_o      (right_o),
        .val_nxt_c_o(r_nxt)
    );

    assign key_ready_o = ready_q;
    assign op_o        = op_q;
    assign display_o   = disp_q;

endmodule

// File: tb/tb_calc_entry.sv
// Scoreboard bench for calc_entry with a behavioural BCD ALU closing the result loop.
module tb_calc_entry;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_valid = 1'b0;
    key_t key = KEY_0;
    logic key_ready;
    num_t left, right, result, display;
    op_t  op;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int    cyc;
        int    disp;
        op_t   op;
        logic  rdy;
        logic  lr_en;
        int    l;
        int    r;
        string name;
    } exp_t;

    exp_t exp_q[$];

    calc_entry dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .key_valid_i(key_valid),
        .key_i      (key),
        .key_ready_o(key_ready),
        .left_o     (left),
        .right_o    (right),
        .op_o       (op),
        .result_i   (result),
        .display_o  (display)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int Mod = 10 ** NumDigits;

    function automatic int to_int(input num_t v);
        int r = 0;
        for (int i = NumDigits - 1; i >= 0; i--) r = r * 10 + int'(v.significand[i]);
        return r;
    endfunction

    function automatic num_t to_num(input int v);
        num_t r;
        int   t = v;
        for (int i = 0; i < NumDigits; i++) begin
            r.significand[i] = digit_t'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Behavioural ALU: ten's-complement wrap on subtraction.
    always_comb begin
        case (op)
            OP_ADD:  result = to_num((to_int(left) + to_int(right)) % Mod);
            OP_SUB:  result = to_num((to_int(left) - to_int(right) + Mod) % Mod);
            default: result = left;
        endcase
    end

    task automatic exp_full(input int off, input int d, input op_t o, input logic rdy,
                            input logic lr_en, input int l, input int r, input string nm);
        exp_t e;
        e.cyc = cyc + off; e.disp = d; e.op = o; e.rdy = rdy;
        e.lr_en = lr_en; e.l = l; e.r = r; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic exp_at(input int off, input int d, input op_t o, input logic rdy, input string nm);
        exp_full(off, d, o, rdy, 1'b0, 0, 0, nm);
    endtask

    // Present a key for one cycle and expect the given state on the following cycle.
    task automatic send(input key_t k, input int d, input op_t o, input logic rdy, input string nm);
        key_valid = 1'b1;
        key = k;
        exp_at(1, d, o, rdy, nm);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic chk(input string nm, input string what, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s %s: got %0d want %0d (cycle %0d)", nm, what, got, want, cyc);
        end
    endtask

    // Monitor: pop every expectation due this cycle and compare against DUT outputs.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s missed: due cycle %0d seen at %0d", e.name, e.cyc, cyc);
            end else begin
                chk(e.name, "display", to_int(display), e.disp);
                chk(e.name, "op", int'(op), int'(e.op));
                chk(e.name, "ready", int'(key_ready), int'(e.rdy));
                if (e.lr_en) begin
                    chk(e.name, "left", to_int(left), e.l);
                    chk(e.name, "right", to_int(right), e.r);
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        exp_full(1, 0, OP_NONE, 1'b1, 1'b1, 0, 0, "reset");
        @(negedge clk);
        rst = 1'b1;
        exp_at(1, 0, OP_NONE, 1'b1, "post_reset");
        @(negedge clk);

        // 12 + 34 = 46, key dropped in exec, then clear
        send(KEY_1, 1, OP_NONE, 1'b1, "add_d1");
        send(KEY_2, 12, OP_NONE, 1'b1, "add_d2");
        send(KEY_ADD, 12, OP_ADD, 1'b1, "add_op");
        send(KEY_3, 3, OP_ADD, 1'b1, "add_r1");
        send(KEY_4, 34, OP_ADD, 1'b1, "add_r2");
        send(KEY_EQ, 34, OP_ADD, 1'b0, "add_exec");
        send(KEY_9, 46, OP_ADD, 1'b1, "add_result_drop");
        exp_full(1, 0, OP_NONE, 1'b1, 1'b1, 0, 0, "clr_result");
        send(KEY_CLR, 0, OP_NONE, 1'b1, "clr_result");

        // Digit overflow and leading zeros
        send(KEY_9, 9, OP_NONE, 1'b1, "ovf_1");
        send(KEY_9, 99, OP_NONE, 1'b1, "ovf_2");
        send(KEY_9, 999, OP_NONE, 1'b1, "ovf_3");
        send(KEY_9, 9999, OP_NONE, 1'b1, "ovf_4");
        send(KEY_9, 9999, OP_NONE, 1'b1, "ovf_5");
        send(KEY_CLR, 0, OP_NONE, 1'b1, "ovf_clr");
        send(KEY_0, 0, OP_NONE, 1'b1, "lz_0a");
        send(KEY_0, 0, OP_NONE, 1'b1, "lz_0b");
        send(KEY_5, 5, OP_NONE, 1'b1, "lz_5");
        send(KEY_1, 51, OP_NONE, 1'b1, "lz_1");
        send(KEY_2, 512, OP_NONE, 1'b1, "lz_2");
        send(KEY_3, 5123, OP_NONE, 1'b1, "lz_3");
        send(KEY_4, 5123, OP_NONE, 1'b1, "lz_full");
        send(KEY_CLR, 0, OP_NONE, 1'b1, "lz_clr");

        // Chained 5 + 3 - 2 = 6
        send(KEY_5, 5, OP_NONE, 1'b1, "ch_d5");
        send(KEY_ADD, 5, OP_ADD, 1'b1, "ch_add");
        send(KEY_3, 3, OP_ADD, 1'b1, "ch_d3");
        send(KEY_SUB, 3, OP_ADD, 1'b0, "ch_exec");
        exp_full(1, 8, OP_SUB, 1'b1, 1'b1, 8, 3, "ch_partial");
        @(negedge clk);
        send(KEY_2, 2, OP_SUB, 1'b1, "ch_d2");
        send(KEY_EQ, 2, OP_SUB, 1'b0, "ch_exec2");
        exp_at(1, 6, OP_SUB, 1'b1, "ch_result");
        @(negedge clk);

        // Op replacement: 7 + then - 2 = 5, new entry from result, EQ ignored in S_LEFT
        send(KEY_7, 7, OP_NONE, 1'b1, "rep_d7");
        send(KEY_ADD, 7, OP_ADD, 1'b1, "rep_add");
        send(KEY_SUB, 7, OP_SUB, 1'b1, "rep_sub");
        send(KEY_2, 2, OP_SUB, 1'b1, "rep_d2");
        send(KEY_EQ, 2, OP_SUB, 1'b0, "rep_exec");
        exp_at(1, 5, OP_SUB, 1'b1, "rep_result");
        @(negedge clk);
        send(KEY_4, 4, OP_NONE, 1'b1, "res_digit");
        exp_full(1, 4, OP_NONE, 1'b1, 1'b1, 4, 2, "left_eq_ignored");
        send(KEY_EQ, 4, OP_NONE, 1'b1, "left_eq_ignored");

        // Clear while entering right operand
        send(KEY_ADD, 4, OP_ADD, 1'b1, "cr_add");
        send(KEY_6, 6, OP_ADD, 1'b1, "cr_d6");
        exp_full(1, 0, OP_NONE, 1'b1, 1'b1, 0, 0, "cr_clr");
        send(KEY_CLR, 0, OP_NONE, 1'b1, "cr_clr");
        send(KEY_3, 3, OP_NONE, 1'b1, "cr_left");

        // 3 - 5 wraps to 9998, then 9998 + 3 wraps to 0001
        send(KEY_SUB, 3, OP_SUB, 1'b1, "neg_sub");
        send(KEY_5, 5, OP_SUB, 1'b1, "neg_d5");
        send(KEY_EQ, 5, OP_SUB, 1'b0, "neg_exec");
        exp_full(1, 9998, OP_SUB, 1'b1, 1'b1, 9998, 5, "neg_result");
        @(negedge clk);
        send(KEY_ADD, 9998, OP_ADD, 1'b1, "wrap_add");
        send(KEY_3, 3, OP_ADD, 1'b1, "wrap_d3");
        send(KEY_EQ, 3, OP_ADD, 1'b0, "wrap_exec");
        exp_at(1, 1, OP_ADD, 1'b1, "wrap_result");
        @(negedge clk);

        // Reset during exec discards the result
        send(KEY_CLR, 0, OP_NONE, 1'b1, "re_clr");
        send(KEY_1, 1, OP_NONE, 1'b1, "re_d1");
        send(KEY_ADD, 1, OP_ADD, 1'b1, "re_add");
        send(KEY_2, 2, OP_ADD, 1'b1, "re_d2");
        send(KEY_EQ, 2, OP_ADD, 1'b0, "re_exec");
        rst = 1'b0;
        exp_full(1, 0, OP_NONE, 1'b1, 1'b1, 0, 0, "re_reset");
        @(negedge clk);
        rst = 1'b1;
        exp_full(1, 0, OP_NONE, 1'b1, 1'b1, 0, 0, "re_release");
        @(negedge clk);
        send(KEY_7, 7, OP_NONE, 1'b1, "re_digit");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
